// File: rtl/addsub_arbiter.sv
// Round-robin front end for a single shared combinational adder_sub.
// Two requesters use a req/done handshake. Operands and the result are registered.
module addsub_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             s0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             s1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_s,
    input  logic [WIDTH-1:0] add_out,
    input  logic             add_cob,
    output logic [WIDTH-1:0] res,
    output logic             cob,
    output logic             done0,
    output logic             done1,
    output logic             gnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   prio;
    logic   grant;
    logic   winner;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        winner     = (req0 && req1) ? prio : req1;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC:    state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only. Reset is synchronous, so it is
    // sampled inside the clocked block.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            prio  <= 1'b0;
            add_a <= '0;
            add_b <= '0;
            add_s <= 1'b0;
            res   <= '0;
            cob   <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            gnt   <= 1'b0;
        end else begin
            state <= state_next;
            done0 <= 1'b0;
            done1 <= 1'b0;
            if (grant) begin
                // Operands are sampled only at grant. After that, requesters may change them freely.
                add_a <= winner ? a1 : a0;
                add_b <= winner ? b1 : b0;
                add_s <= winner ? s1 : s0;
                gnt   <= winner;
                prio  <= ~winner;
            end
            if (state == EXEC) begin
                res   <= add_out;
                cob   <= add_cob;
                done0 <= ~gnt;
                done1 <= gnt;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed bench for addsub_arbiter. The shared adder_sub is modelled as
// A + B, or A + ~B + 1 when subtracting, and COB is the carry out.
module tb_addsub_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1, s0, s1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [WIDTH-1:0] add_a, add_b, add_out, res;
    logic             add_s, add_cob, cob, done0, done1, gnt, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behaviour of the shared adder_sub that the arbiter drives.
    logic [WIDTH:0] sum;
    assign sum     = {1'b0, add_a} + {1'b0, (add_s ? ~add_b : add_b)} + {{WIDTH{1'b0}}, add_s};
    assign add_out = sum[WIDTH-1:0];
    assign add_cob = sum[WIDTH];

    addsub_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .s0(s0),
        .req1(req1), .a1(a1), .b1(b1), .s1(s1),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .add_out(add_out), .add_cob(add_cob),
        .res(res), .cob(cob), .done0(done0), .done1(done1),
        .gnt(gnt), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle 1 ns past the edge before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int n_done;

    initial begin
        rst = 1'b1; req0 = 0; req1 = 0; s0 = 0; s1 = 0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        step(); step();
        rst = 1'b0;
        check("rst_res", res, 0);
        check("rst_cob", cob, 0);
        check("rst_done", {done1, done0}, 0);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_add", {add_s, add_b, add_a}, 0);

        // 1: requester 0 adds 22h + 11h.
        req0 = 1; a0 = 8'h22; b0 = 8'h11; s0 = 0;
        step();
        check("t1_busy", busy, 1);
        check("t1_operands", {add_s, add_a, add_b}, {1'b0, 8'h22, 8'h11});
        check("t1_early_done", {done1, done0}, 0);
        step();
        check("t1_done", {done1, done0}, 2'b01);
        check("t1_res", {cob, res}, {1'b0, 8'h33});
        req0 = 0;
        step();
        check("t1_done_clear", {done1, done0}, 0);
        check("t1_idle", busy, 0);

        // 2: requester 1 subtracts 33h - 15h. Its request stays high for a second op
        //    because a lone requester is served again regardless of prio.
        req1 = 1; a1 = 8'h33; b1 = 8'h15; s1 = 1;
        step(); step();
        check("t2_done", {done1, done0}, 2'b10);
        check("t2_res", {cob, res}, {1'b1, 8'h1E});
        check("t2_gnt", gnt, 1);
        step();
        check("t2_hold_res", res, 8'h1E);
        step();
        check("t2_again_gnt", gnt, 1);
        step();
        check("t2_again_done", {done1, done0}, 2'b10);
        req1 = 0;
        step();

        // 3: both requesters start together straight out of reset.
        rst = 1; step(); rst = 0;
        req0 = 1; a0 = 8'h44; b0 = 8'h33; s0 = 1;
        req1 = 1; a1 = 8'h33; b1 = 8'h55; s1 = 1;
        step(); step();
        check("t3_first_done", {done1, done0}, 2'b01);
        check("t3_first_res", {cob, res}, {1'b1, 8'h11});
        req0 = 0;
        step();
        check("t3_gap1", {done1, done0}, 0);
        step();
        check("t3_gap2", {done1, done0}, 0);
        step();
        check("t3_second_done", {done1, done0}, 2'b10);
        check("t3_second_res", {cob, res}, {1'b0, 8'hDE});
        req1 = 0;
        step();

        // 4: both requesters hold their requests for six operations. Grants alternate 0,1,0,1,...
        req0 = 1; a0 = 8'h01; b0 = 8'h02; s0 = 0;
        req1 = 1; a1 = 8'h10; b1 = 8'h01; s1 = 1;
        n_done = 0;
        for (int c = 0; c < 18; c++) begin
            step();
            check("t4_exclusive", done0 & done1, 0);
            if (done0 | done1) begin
                check("t4_slot", c % 3, 1);
                check("t4_gnt", gnt, n_done % 2);
                check("t4_done_id", {done1, done0}, (n_done % 2) ? 2 : 1);
                check("t4_res", res, (n_done % 2) ? 8'h0F : 8'h03);
                n_done++;
            end
        end
        check("t4_count", n_done, 6);
        req0 = 0; req1 = 0;
        step(); step(); step();

        // 5: reset arrives during EXEC. The operation is aborted and no done pulse is issued.
        req0 = 1; a0 = 8'h10; b0 = 8'h20; s0 = 0;
        step();
        check("t5_exec", busy, 1);
        rst = 1; req0 = 0;
        step();
        rst = 0;
        check("t5_no_done", {done1, done0}, 0);
        check("t5_cleared", {busy, gnt, cob, res, add_s, add_a, add_b}, 0);
        step();
        check("t5_still_no_done", {done1, done0}, 0);
        req0 = 1; a0 = 8'h33; b0 = 8'h66; s0 = 0;
        step(); step();
        check("t5_done", {done1, done0}, 2'b01);
        check("t5_res", {cob, res}, {1'b0, 8'h99});
        req0 = 0;
        step();

        // 6: requester 0 changes operands mid-operation. The result uses the values latched at grant.
        req0 = 1; a0 = 8'h22; b0 = 8'h11; s0 = 0;
        step();
        a0 = 8'hFF;
        step();
        check("t6_done", {done1, done0}, 2'b01);
        check("t6_res", {cob, res}, {1'b0, 8'h33});
        req0 = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
